// File: rtl/hex_display_pkg.sv
// Shared definitions for the hex display scanner: segment lookup table and scan states.
package hex_display_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    // Segment patterns {a,b,c,d,e,f,g} for hex digits 0..F, bit6 = a.
    localparam logic [6:0] SEG7_HEX [0:15] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

endpackage

// File: rtl/hex7_decoder.sv
// Combinational hex nibble to active-high 7-segment pattern.
module hex7_decoder
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG7_HEX[nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex 7-segment scanner with blanking gap and frame-synchronous data update.
// Define HEX_LZ_SUPPRESS_EN to blank leading zero digits (digit 0 always shown).
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_start
);

    localparam int VW      = 4*NUM_DIGITS;
    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? ((SCAN_DIV > 2) ? SCAN_DIV : 2)
                                                       : ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
    localparam int CW      = $clog2(CNT_MAX);
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV-1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES-1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS-1);

    scan_state_e   state, state_nxt;
    logic          run;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [VW-1:0] pending, active, active_nxt;
    logic          boundary;

    logic [NUM_DIGITS-1:0][3:0] nib;
    logic [NUM_DIGITS-1:0][6:0] dec;
    logic [NUM_DIGITS-1:0]      lz;

    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [NUM_DIGITS-1:0] digit_sel_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        case (state)
            BLANK: if (BLANK_CYCLES == 0 || cnt == BLANK_LAST) begin
                state_nxt = DRIVE;
                cnt_nxt   = '0;
            end
            DRIVE: if (cnt == SCAN_LAST) begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
                idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            default: begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A same-edge load bypasses pending so the new word lands in this frame.
    assign boundary   = run && (state == BLANK) && (state_nxt == DRIVE) && (idx == '0);
    assign active_nxt = boundary ? (load ? value : pending) : active;
    assign nib        = active_nxt;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        hex7_decoder u_dec (
            .nibble (nib[g]),
            .seg    (dec[g])
        );
`ifdef HEX_LZ_SUPPRESS_EN
        if (g == 0) begin : g_lz0
            assign lz[g] = 1'b0;
        end else begin : g_lzn
            assign lz[g] = (active_nxt[VW-1:4*g] == '0);
        end
`else
        assign lz[g] = 1'b0;
`endif
    end

    always_comb begin
        digit_sel_nxt = '0;
        seg_nxt       = '0;
        dp_nxt        = 1'b0;
        if (state_nxt == DRIVE) begin
            digit_sel_nxt = NUM_DIGITS'(1) << idx_nxt;
            dp_nxt        = dp_mask[idx_nxt];
            if (!blank_mask[idx_nxt] && !lz[idx_nxt])
                seg_nxt = dec[idx_nxt];
        end
    end

    // run holds the scan off for one edge so release is clean relative to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            state       <= BLANK;
            cnt         <= '0;
            idx         <= '0;
            pending     <= '0;
            active      <= '0;
            seg         <= '0;
            dp          <= 1'b0;
            digit_sel   <= '0;
            frame_start <= 1'b0;
        end else begin
            run <= 1'b1;
            if (load)
                pending <= value;
            if (run) begin
                state       <= state_nxt;
                cnt         <= cnt_nxt;
                idx         <= idx_nxt;
                active      <= active_nxt;
                seg         <= seg_nxt;
                dp          <= dp_nxt;
                digit_sel   <= digit_sel_nxt;
                frame_start <= boundary;
            end
        end
    end

endmodule
